// File: rtl/lsu_addrcheck_win_if.sv
// ---------------------------------------------------------------------------
// lsu_addrcheck_win_if
//   Request/response bundle between the LSU dc1 stage and the address checker.
//   master : drives the dc1 request, observes the dc2/dc3 results
//   slave  : the checker (consumes the request, produces the results)
//
//   Request  : valid_dc1, dma_dc1, size_dc1[1:0], start_addr_dc1, end_addr_dc1
//   Response : valid_dc2, in_dccm_dc2, in_pic_dc2, external_dc2,
//              sideeffects_dc2, sideeffects_dc3, access_fault_dc2,
//              misaligned_fault_dc2, fault_cause_dc2[2:0]
// ---------------------------------------------------------------------------
interface lsu_addrcheck_win_if;
    logic        valid_dc1;
    logic        dma_dc1;
    logic [1:0]  size_dc1;
    logic [31:0] start_addr_dc1;
    logic [31:0] end_addr_dc1;

    logic        valid_dc2;
    logic        in_dccm_dc2;
    logic        in_pic_dc2;
    logic        external_dc2;
    logic        sideeffects_dc2;
    logic        sideeffects_dc3;
    logic        access_fault_dc2;
    logic        misaligned_fault_dc2;
    logic [2:0]  fault_cause_dc2;

    modport master (
        output valid_dc1, dma_dc1, size_dc1, start_addr_dc1, end_addr_dc1,
        input  valid_dc2, in_dccm_dc2, in_pic_dc2, external_dc2,
               sideeffects_dc2, sideeffects_dc3, access_fault_dc2,
               misaligned_fault_dc2, fault_cause_dc2
    );

    modport slave (
        input  valid_dc1, dma_dc1, size_dc1, start_addr_dc1, end_addr_dc1,
        output valid_dc2, in_dccm_dc2, in_pic_dc2, external_dc2,
               sideeffects_dc2, sideeffects_dc3, access_fault_dc2,
               misaligned_fault_dc2, fault_cause_dc2
    );
endinterface

// File: rtl/lsu_addrcheck_win.sv
// ---------------------------------------------------------------------------
// lsu_addrcheck_win
//   Pipelined LSU address checker. Each dc1 access is classified as DCCM,
//   PIC or external, checked against NUM_WIN programmable/lockable access
//   windows, and given a side-effect attribute from the MRAC vector. Results
//   register into dc2; the side-effect bit is also carried into dc3. A
//   first-fault capture register and a saturating fault counter aid debug.
//
//   clk, rst        : clock, synchronous active-high reset
//   freeze          : holds dc2/dc3, capture and counter state
//   bus (slave)     : dc1 request in, dc2/dc3 results out
//   mrac            : 2 bits per region {side-effect, cacheable}
//   cfg_*           : window register write port (ignored for locked windows)
//   cap_clr         : clears the capture register
//   cap_valid/addr/cause, fault_cnt : debug capture and fault count
// ---------------------------------------------------------------------------
module lsu_addrcheck_win #(
    parameter int          NUM_WIN     = 8,
    parameter int          REGION_BITS = 4,
    parameter logic [31:0] DCCM_SADR   = 32'hF004_0000,
    parameter logic [31:0] DCCM_SIZE   = 32'h0001_0000,
    parameter logic [31:0] PIC_SADR    = 32'hF00C_0000,
    parameter logic [31:0] PIC_SIZE    = 32'h0000_8000,
    parameter int          CNT_W       = 16,
    localparam int         IDX_W       = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          freeze,
    lsu_addrcheck_win_if.slave            bus,
    input  logic [(2 << REGION_BITS)-1:0] mrac,
    input  logic                          cfg_we,
    input  logic [IDX_W-1:0]              cfg_idx,
    input  logic [31:0]                   cfg_base,
    input  logic [31:0]                   cfg_mask,
    input  logic                          cfg_en,
    input  logic                          cfg_lock,
    input  logic                          cap_clr,
    output logic                          cap_valid,
    output logic [31:0]                   cap_addr,
    output logic [2:0]                    cap_cause,
    output logic [CNT_W-1:0]              fault_cnt
);

    localparam logic [REGION_BITS-1:0] DCCM_RGN = DCCM_SADR[31 -: REGION_BITS];
    localparam logic [REGION_BITS-1:0] PIC_RGN  = PIC_SADR[31 -: REGION_BITS];

    // 33-bit compare so a range ending at the top of the map cannot wrap
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] size);
        logic [32:0] lim;
        lim = {1'b0, base} + {1'b0, size};
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < lim);
    endfunction

    // Lowest-numbered active cause wins
    function automatic logic [2:0] first_cause(input logic [6:1] c);
        logic [2:0] r;
        r = 3'd0;
        for (int k = 6; k >= 1; k--) begin
            if (c[k]) r = 3'(k);
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Window registers
    logic [31:0]        win_base [NUM_WIN];
    logic [31:0]        win_mask [NUM_WIN];
    logic [NUM_WIN-1:0] win_en;
    logic [NUM_WIN-1:0] win_lock;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                win_base[i] <= '0;
                win_mask[i] <= '0;
            end
            win_en   <= '0;
            win_lock <= '0;
        end else if (cfg_we) begin
            // indices beyond NUM_WIN-1 match no entry and are dropped
            for (int i = 0; i < NUM_WIN; i++) begin
                if (cfg_idx == IDX_W'(i) && !win_lock[i]) begin
                    win_base[i] <= cfg_base;
                    win_mask[i] <= cfg_mask;
                    win_en[i]   <= cfg_en;
                    win_lock[i] <= cfg_lock;
                end
            end
        end
    end

    // ---- dc1: classification and fault detection (p0) ----
    logic [31:0]            sa, ea;
    logic [REGION_BITS-1:0] start_rgn, end_rgn;
    logic s_dccm_rgn, e_dccm_rgn, s_pic_rgn, e_pic_rgn;
    logic s_in_dccm, e_in_dccm, s_in_pic, e_in_pic;
    logic in_dccm_p0, in_pic_p0, external_p0, se_p0;
    logic aligned_p0, word_ok_p0;
    logic any_en, start_hit, end_hit, win_ok;
    logic [6:1] cause_vec;
    logic req_live, access_fault_p0, misaligned_fault_p0, fault_p0;
    logic [2:0] cause_p0;

    assign sa        = bus.start_addr_dc1;
    assign ea        = bus.end_addr_dc1;
    assign start_rgn = sa[31 -: REGION_BITS];
    assign end_rgn   = ea[31 -: REGION_BITS];

    assign s_dccm_rgn = (start_rgn == DCCM_RGN);
    assign e_dccm_rgn = (end_rgn   == DCCM_RGN);
    assign s_pic_rgn  = (start_rgn == PIC_RGN);
    assign e_pic_rgn  = (end_rgn   == PIC_RGN);

    assign s_in_dccm = in_range(sa, DCCM_SADR, DCCM_SIZE);
    assign e_in_dccm = in_range(ea, DCCM_SADR, DCCM_SIZE);
    assign s_in_pic  = in_range(sa, PIC_SADR, PIC_SIZE);
    assign e_in_pic  = in_range(ea, PIC_SADR, PIC_SIZE);

    assign in_dccm_p0  = s_in_dccm & e_in_dccm;
    assign in_pic_p0   = s_in_pic & e_in_pic;
    assign external_p0 = ~(in_dccm_p0 | in_pic_p0);
    assign se_p0       = mrac[{start_rgn, 1'b1}] & ~(s_dccm_rgn | s_pic_rgn);

    always_comb begin
        case (bus.size_dc1)
            2'd2:    aligned_p0 = (sa[1:0] == 2'b00);
            2'd1:    aligned_p0 = ~sa[0];
            default: aligned_p0 = 1'b1;
        endcase
    end
    assign word_ok_p0 = (bus.size_dc1 == 2'd2) && (sa[1:0] == 2'b00);

    // Start and end may be covered by different windows
    always_comb begin
        any_en    = 1'b0;
        start_hit = 1'b0;
        end_hit   = 1'b0;
        for (int i = 0; i < NUM_WIN; i++) begin
            any_en    = any_en | win_en[i];
            start_hit = start_hit |
                        (win_en[i] && ((sa | win_mask[i]) == (win_base[i] | win_mask[i])));
            end_hit   = end_hit |
                        (win_en[i] && ((ea | win_mask[i]) == (win_base[i] | win_mask[i])));
        end
    end
    assign win_ok = ~any_en | (start_hit & end_hit);

    assign cause_vec = {
        external_p0 & se_p0 & ~aligned_p0,                                    // 6
        external_p0 & (start_rgn != end_rgn),                                 // 5
        ~(s_dccm_rgn | s_pic_rgn) & ~win_ok,                                  // 4
        in_pic_p0 & ~word_ok_p0,                                              // 3
        (s_pic_rgn & ~(s_in_dccm | s_in_pic)) | (e_pic_rgn & ~(e_in_dccm | e_in_pic)) |
        (s_in_dccm & e_in_pic) | (s_in_pic & e_in_dccm),                      // 2
        (s_dccm_rgn & ~(s_in_dccm | s_in_pic)) | (e_dccm_rgn & ~(e_in_dccm | e_in_pic))  // 1
    };

    assign req_live            = bus.valid_dc1 & ~bus.dma_dc1;
    assign access_fault_p0     = req_live & (|cause_vec[4:1]);
    assign misaligned_fault_p0 = req_live & (|cause_vec[6:5]);
    assign cause_p0            = req_live ? first_cause(cause_vec) : 3'd0;
    assign fault_p0            = access_fault_p0 | misaligned_fault_p0;

    // ---- dc2 (p1) / dc3 (p2) registers ----
    logic       vld_p1, in_dccm_p1, in_pic_p1, external_p1, se_p1, se_p2;
    logic       access_fault_p1, misaligned_fault_p1;
    logic [2:0] cause_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1              <= 1'b0;
            in_dccm_p1          <= 1'b0;
            in_pic_p1           <= 1'b0;
            external_p1         <= 1'b0;
            se_p1               <= 1'b0;
            se_p2               <= 1'b0;
            access_fault_p1     <= 1'b0;
            misaligned_fault_p1 <= 1'b0;
            cause_p1            <= 3'd0;
        end else if (!freeze) begin
            vld_p1              <= bus.valid_dc1;
            in_dccm_p1          <= bus.valid_dc1 & in_dccm_p0;
            in_pic_p1           <= bus.valid_dc1 & in_pic_p0;
            external_p1         <= bus.valid_dc1 & external_p0;
            se_p1               <= se_p0;
            se_p2               <= se_p1;
            access_fault_p1     <= access_fault_p0;
            misaligned_fault_p1 <= misaligned_fault_p0;
            cause_p1            <= cause_p0;
        end
    end

    assign bus.valid_dc2            = vld_p1;
    assign bus.in_dccm_dc2          = in_dccm_p1;
    assign bus.in_pic_dc2           = in_pic_p1;
    assign bus.external_dc2         = external_p1;
    assign bus.sideeffects_dc2      = se_p1;
    assign bus.sideeffects_dc3      = se_p2;
    assign bus.access_fault_dc2     = access_fault_p1;
    assign bus.misaligned_fault_dc2 = misaligned_fault_p1;
    assign bus.fault_cause_dc2      = cause_p1;

    // ---- debug capture and fault counter (advance with dc2) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_valid <= 1'b0;
            cap_addr  <= '0;
            cap_cause <= 3'd0;
            fault_cnt <= '0;
        end else begin
            if (!freeze && fault_p0) begin
                fault_cnt <= sat_inc(fault_cnt);
            end
            // a fault arriving with cap_clr replaces the old capture
            if (!freeze && fault_p0 && (!cap_valid || cap_clr)) begin
                cap_valid <= 1'b1;
                cap_addr  <= sa;
                cap_cause <= cause_p0;
            end else if (cap_clr) begin
                cap_valid <= 1'b0;
                cap_addr  <= '0;
                cap_cause <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_addrcheck_win.sv
module tb_lsu_addrcheck_win;
    localparam int          NW        = 6;
    localparam int          CW        = 4;
    localparam int          CNT_MAX   = 15;
    localparam logic [31:0] DCCM_SADR = 32'hF004_0000;
    localparam logic [31:0] DCCM_SIZE = 32'h0001_0000;
    localparam logic [31:0] PIC_SADR  = 32'hF00C_0000;
    localparam logic [31:0] PIC_SIZE  = 32'h0000_8000;

    typedef struct packed {
        logic vld, dccm, pic, ext, se, af, mf;
        logic [2:0] cause;
    } res_t;

    logic          clk = 1'b0;
    logic          rst, freeze, cfg_we, cfg_en, cfg_lock, cap_clr;
    logic [31:0]   mrac, cfg_base, cfg_mask;
    logic [2:0]    cfg_idx;
    logic          cap_valid;
    logic [31:0]   cap_addr;
    logic [2:0]    cap_cause;
    logic [CW-1:0] fault_cnt;

    lsu_addrcheck_win_if bus();

    lsu_addrcheck_win #(.NUM_WIN(NW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .bus(bus), .mrac(mrac),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base), .cfg_mask(cfg_mask),
        .cfg_en(cfg_en), .cfg_lock(cfg_lock), .cap_clr(cap_clr),
        .cap_valid(cap_valid), .cap_addr(cap_addr), .cap_cause(cap_cause),
        .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit [31:0] m_base [8];
    bit [31:0] m_mask [8];
    bit        m_en   [8];
    bit        m_lock [8];
    res_t      m_res;
    bit        m_se3, m_cap_valid;
    bit [31:0] m_cap_addr;
    bit [2:0]  m_cap_cause;
    int        m_cnt;

    function automatic int rgn(input logic [31:0] a);
        return int'(a >> 28);
    endfunction

    function automatic bit in_rng(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
        longint unsigned x, lo, hi;
        x = longint'(a); lo = longint'(b); hi = lo + longint'(s);
        return (x >= lo) && (x < hi);
    endfunction

    function automatic bit win_cover(input logic [31:0] a);
        bit h = 0;
        for (int i = 0; i < NW; i++)
            if (m_en[i] && ((a | m_mask[i]) == (m_base[i] | m_mask[i]))) h = 1;
        return h;
    endfunction

    function automatic res_t ref_check(input logic [31:0] s, input logic [31:0] e,
                                       input logic [1:0] sz, input logic v, input logic d,
                                       input logic [31:0] mr);
        res_t r;
        bit sdr, edr, spr, epr, sd, ed, sp, ep, dccm, pic, ext, se, ok, aligned, any_en, gate;
        bit c [7];
        sdr = rgn(s) == rgn(DCCM_SADR); edr = rgn(e) == rgn(DCCM_SADR);
        spr = rgn(s) == rgn(PIC_SADR);  epr = rgn(e) == rgn(PIC_SADR);
        sd = in_rng(s, DCCM_SADR, DCCM_SIZE); ed = in_rng(e, DCCM_SADR, DCCM_SIZE);
        sp = in_rng(s, PIC_SADR, PIC_SIZE);   ep = in_rng(e, PIC_SADR, PIC_SIZE);
        dccm = sd && ed; pic = sp && ep; ext = !(dccm || pic);
        se = mr[2 * rgn(s) + 1] && !(sdr || spr);
        any_en = 0;
        for (int i = 0; i < NW; i++) if (m_en[i]) any_en = 1;
        ok = !any_en || (win_cover(s) && win_cover(e));
        aligned = (sz == 2) ? (s % 4 == 0) : (sz == 1) ? (s % 2 == 0) : 1;
        c[0] = 0;
        c[1] = (sdr && !(sd || sp)) || (edr && !(ed || ep));
        c[2] = (spr && !(sd || sp)) || (epr && !(ed || ep)) || (sd && ep) || (sp && ed);
        c[3] = pic && !(sz == 2 && s % 4 == 0);
        c[4] = !(sdr || spr) && !ok;
        c[5] = ext && rgn(s) != rgn(e);
        c[6] = ext && se && !aligned;
        gate = v && !d;
        r.cause = 0;
        for (int k = 6; k >= 1; k--) if (gate && c[k]) r.cause = 3'(k);
        r.af = gate && (c[1] || c[2] || c[3] || c[4]);
        r.mf = gate && (c[5] || c[6]);
        r.vld = v; r.dccm = v && dccm; r.pic = v && pic; r.ext = v && ext; r.se = se;
        return r;
    endfunction

    function automatic logic [9:0] dc2_vec();
        return {bus.valid_dc2, bus.in_dccm_dc2, bus.in_pic_dc2, bus.external_dc2,
                bus.sideeffects_dc2, bus.access_fault_dc2, bus.misaligned_fault_dc2,
                bus.fault_cause_dc2};
    endfunction

    function automatic logic [9:0] pack(input bit v, d, p, x, se, af, mf, input int cause);
        return {v, d, p, x, se, af, mf, 3'(cause)};
    endfunction

    // one clock edge; the model advances using the inputs present before the edge
    task automatic tick();
        res_t r;
        bit flt;
        r = ref_check(bus.start_addr_dc1, bus.end_addr_dc1, bus.size_dc1,
                      bus.valid_dc1, bus.dma_dc1, mrac);
        flt = r.af || r.mf;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_base[i] = 0; m_mask[i] = 0; m_en[i] = 0; m_lock[i] = 0;
            end
            m_res = '0; m_se3 = 0; m_cap_valid = 0; m_cap_addr = 0; m_cap_cause = 0; m_cnt = 0;
        end else begin
            if (cfg_we && cfg_idx < NW && !m_lock[cfg_idx]) begin
                m_base[cfg_idx] = cfg_base; m_mask[cfg_idx] = cfg_mask;
                m_en[cfg_idx] = cfg_en;     m_lock[cfg_idx] = cfg_lock;
            end
            if (!freeze) begin
                m_se3 = m_res.se;
                m_res = r;
                if (flt && m_cnt < CNT_MAX) m_cnt++;
            end
            if (!freeze && flt && (!m_cap_valid || cap_clr)) begin
                m_cap_valid = 1; m_cap_addr = bus.start_addr_dc1; m_cap_cause = r.cause;
            end else if (cap_clr) begin
                m_cap_valid = 0; m_cap_addr = 0; m_cap_cause = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] s, input logic [31:0] e,
                             input logic [1:0] sz, input logic dma);
        bus.valid_dc1 = 1; bus.dma_dc1 = dma; bus.size_dc1 = sz;
        bus.start_addr_dc1 = s; bus.end_addr_dc1 = e;
    endtask

    task automatic idle();
        bus.valid_dc1 = 0; bus.dma_dc1 = 0; bus.size_dc1 = 0;
        bus.start_addr_dc1 = 0; bus.end_addr_dc1 = 0;
    endtask

    task automatic set_cfg(input logic we, input logic [2:0] idx, input logic [31:0] base,
                           input logic [31:0] mask, input logic en, input logic lock);
        cfg_we = we; cfg_idx = idx; cfg_base = base; cfg_mask = mask; cfg_en = en; cfg_lock = lock;
    endtask

    task automatic apply_reset();
        rst = 1; freeze = 0; cap_clr = 0; mrac = 0;
        set_cfg(0, 0, 0, 0, 0, 0);
        idle();
        tick(); tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; freeze = 0; cap_clr = 0; mrac = 32'hFFFF_FFFF;
        set_cfg(0, 0, 0, 0, 0, 0);
        drive_req(32'h4000_0001, 32'h5000_0002, 2'd1, 0);
        tick(); tick();
        n_checks++;
        if (dc2_vec() !== 10'd0 || bus.sideeffects_dc3 !== 1'b0) begin
            n_errors++; $display("FAIL reset_dc2 got %b/%b exp 0/0", dc2_vec(), bus.sideeffects_dc3);
        end
        n_checks++;
        if ({cap_valid, cap_addr, cap_cause, fault_cnt} !== '0) begin
            n_errors++; $display("FAIL reset_cap got v%b a%h c%0d n%0d exp all 0", cap_valid, cap_addr, cap_cause, fault_cnt);
        end
        rst = 0; mrac = 0; idle();
    endtask

    task automatic test_external();
        apply_reset();
        drive_req(32'h2000_0000, 32'h2000_0003, 2'd2, 0);
        tick();
        n_checks++;
        if (dc2_vec() !== pack(1,0,0,1,0,0,0,0) || fault_cnt !== 0) begin
            n_errors++; $display("FAIL ext_load got %b cnt %0d exp %b cnt 0", dc2_vec(), fault_cnt, pack(1,0,0,1,0,0,0,0));
        end
        idle();
        tick();
        n_checks++;
        if (dc2_vec() !== 10'd0) begin
            n_errors++; $display("FAIL ext_idle got %b exp 0", dc2_vec());
        end
    endtask

    task automatic test_window();
        apply_reset();
        set_cfg(1, 0, 32'h2000_0000, 32'h0FFF_FFFF, 1, 0);
        drive_req(32'h3000_0000, 32'h3000_0003, 2'd2, 0);
        tick();
        n_checks++;
        if (dc2_vec() !== pack(1,0,0,1,0,0,0,0)) begin
            n_errors++; $display("FAIL win_same_cycle got %b exp %b", dc2_vec(), pack(1,0,0,1,0,0,0,0));
        end
        set_cfg(0, 0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (dc2_vec() !== pack(1,0,0,1,0,1,0,4)) begin
            n_errors++; $display("FAIL win_miss got %b exp %b", dc2_vec(), pack(1,0,0,1,0,1,0,4));
        end
        n_checks++;
        if (cap_valid !== 1 || cap_addr !== 32'h3000_0000 || cap_cause !== 4 || fault_cnt !== 1) begin
            n_errors++; $display("FAIL win_cap got v%b a%h c%0d n%0d exp v1 a30000000 c4 n1", cap_valid, cap_addr, cap_cause, fault_cnt);
        end
        drive_req(32'h2000_0010, 32'h2000_0013, 2'd2, 0);
        tick();
        n_checks++;
        if (dc2_vec() !== pack(1,0,0,1,0,0,0,0) || fault_cnt !== 1) begin
            n_errors++; $display("FAIL win_hit got %b cnt %0d exp %b cnt 1", dc2_vec(), fault_cnt, pack(1,0,0,1,0,0,0,0));
        end
    endtask

    task automatic test_lock_dma();
        apply_reset();
        set_cfg(1, 0, 32'h2000_0000, 32'h0FFF_FFFF, 1, 1);
        tick();
        set_cfg(1, 0, 32'h0, 32'h0, 0, 0);
        tick();
        set_cfg(1, 7, 32'h3000_0000, 32'h0FFF_FFFF, 1, 0);
        tick();
        set_cfg(0, 0, 0, 0, 0, 0);
        drive_req(32'h3000_0000, 32'h3000_0003, 2'd2, 0);
        tick();
        n_checks++;
        if (dc2_vec() !== pack(1,0,0,1,0,1,0,4) || fault_cnt !== 1) begin
            n_errors++; $display("FAIL lock_held got %b cnt %0d exp %b cnt 1", dc2_vec(), fault_cnt, pack(1,0,0,1,0,1,0,4));
        end
        drive_req(32'h2000_0010, 32'h2000_0013, 2'd2, 0);
        tick();
        n_checks++;
        if (dc2_vec() !== pack(1,0,0,1,0,0,0,0)) begin
            n_errors++; $display("FAIL lock_hit got %b exp %b", dc2_vec(), pack(1,0,0,1,0,0,0,0));
        end
        drive_req(32'h3000_0000, 32'h3000_0003, 2'd2, 1);
        tick();
        n_checks++;
        if (dc2_vec() !== pack(1,0,0,1,0,0,0,0) || fault_cnt !== 1) begin
            n_errors++; $display("FAIL dma_nofault got %b cnt %0d exp %b cnt 1", dc2_vec(), fault_cnt, pack(1,0,0,1,0,0,0,0));
        end
    endtask

    task automatic test_dccm_pic();
        apply_reset();
        drive_req(32'hF004_FFFE, 32'hF005_0001, 2'd2, 0);
        tick();
        n_checks++;
        if (dc2_vec() !== pack(1,0,0,1,0,1,0,1) || cap_addr !== 32'hF004_FFFE || cap_cause !== 1) begin
            n_errors++; $display("FAIL dccm_overrun got %b a%h c%0d exp %b aF004FFFE c1", dc2_vec(), cap_addr, cap_cause, pack(1,0,0,1,0,1,0,1));
        end
        drive_req(32'hF00C_0000, 32'hF00C_0001, 2'd1, 0);
        tick();
        n_checks++;
        if (dc2_vec() !== pack(1,0,1,0,0,1,0,3) || cap_cause !== 1) begin
            n_errors++; $display("FAIL pic_half got %b c%0d exp %b c1", dc2_vec(), cap_cause, pack(1,0,1,0,0,1,0,3));
        end
        drive_req(32'hF004_0000, 32'hF004_0003, 2'd2, 0);
        tick();
        n_checks++;
        if (dc2_vec() !== pack(1,1,0,0,0,0,0,0)) begin
            n_errors++; $display("FAIL dccm_word got %b exp %b", dc2_vec(), pack(1,1,0,0,0,0,0,0));
        end
        drive_req(32'hF004_FFFC, 32'hF00C_0000, 2'd2, 0);
        tick();
        n_checks++;
        if (dc2_vec() !== pack(1,0,0,1,0,1,0,2) || fault_cnt !== 3) begin
            n_errors++; $display("FAIL dccm_pic_cross got %b cnt %0d exp %b cnt 3", dc2_vec(), fault_cnt, pack(1,0,0,1,0,1,0,2));
        end
    endtask

    task automatic test_sideeffect_freeze();
        apply_reset();
        mrac = 32'h0000_0200;
        drive_req(32'h4000_0001, 32'h4000_0002, 2'd1, 0);
        tick();
        n_checks++;
        if (dc2_vec() !== pack(1,0,0,1,1,0,1,6) || bus.sideeffects_dc3 !== 0) begin
            n_errors++; $display("FAIL se_store got %b/%b exp %b/0", dc2_vec(), bus.sideeffects_dc3, pack(1,0,0,1,1,0,1,6));
        end
        freeze = 1;
        drive_req(32'hF00C_0000, 32'hF00C_0001, 2'd1, 0);
        for (int k = 0; k < 3; k++) begin
            cap_clr = (k == 2);
            tick();
            n_checks++;
            if (dc2_vec() !== pack(1,0,0,1,1,0,1,6) || bus.sideeffects_dc3 !== 0 || fault_cnt !== 1) begin
                n_errors++; $display("FAIL freeze_hold%0d got %b/%b cnt %0d exp %b/0 cnt 1", k, dc2_vec(), bus.sideeffects_dc3, fault_cnt, pack(1,0,0,1,1,0,1,6));
            end
        end
        n_checks++;
        if (cap_valid !== 0) begin
            n_errors++; $display("FAIL freeze_capclr got %b exp 0", cap_valid);
        end
        freeze = 0; cap_clr = 0;
        idle();
        tick();
        n_checks++;
        if (dc2_vec() !== 10'd0 || bus.sideeffects_dc3 !== 1 || fault_cnt !== 1) begin
            n_errors++; $display("FAIL se_dc3 got %b/%b cnt %0d exp 0/1 cnt 1", dc2_vec(), bus.sideeffects_dc3, fault_cnt);
        end
    endtask

    task automatic test_saturate_capture();
        apply_reset();
        drive_req(32'hF00C_0000, 32'hF00C_0001, 2'd1, 0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            n_checks++;
            if (fault_cnt !== CW'((k > CNT_MAX) ? CNT_MAX : k)) begin
                n_errors++; $display("FAIL sat_cnt%0d got %0d exp %0d", k, fault_cnt, (k > CNT_MAX) ? CNT_MAX : k);
            end
        end
        n_checks++;
        if (cap_valid !== 1 || cap_addr !== 32'hF00C_0000 || cap_cause !== 3) begin
            n_errors++; $display("FAIL sat_cap got v%b a%h c%0d exp v1 aF00C0000 c3", cap_valid, cap_addr, cap_cause);
        end
        cap_clr = 1;
        drive_req(32'h5000_0000, 32'h6000_0003, 2'd2, 0);
        tick();
        n_checks++;
        if (cap_valid !== 1 || cap_addr !== 32'h5000_0000 || cap_cause !== 5 || fault_cnt !== CNT_MAX) begin
            n_errors++; $display("FAIL clr_newfault got v%b a%h c%0d n%0d exp v1 a50000000 c5 n15", cap_valid, cap_addr, cap_cause, fault_cnt);
        end
        idle();
        tick();
        n_checks++;
        if (cap_valid !== 0 || cap_addr !== 0) begin
            n_errors++; $display("FAIL clr_only got v%b a%h exp v0 a0", cap_valid, cap_addr);
        end
        cap_clr = 0;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0: return DCCM_SADR + $urandom_range(0, 15);
            1: return DCCM_SADR + DCCM_SIZE - $urandom_range(1, 8);
            2: return PIC_SADR + $urandom_range(0, 15);
            3: return PIC_SADR + PIC_SIZE - $urandom_range(1, 8);
            4: return {4'($urandom_range(1, 5)), 28'($urandom_range(0, 63))};
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] s;
        logic [1:0]  sz;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 99) == 0);
            freeze  = ($urandom_range(0, 7) == 0);
            cap_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) mrac = $urandom;
            set_cfg($urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 1) == 0) ? {4'($urandom_range(1, 5)), 28'h0} : $urandom,
                    ($urandom_range(0, 1) == 0) ? 32'h0FFF_FFFF : $urandom,
                    $urandom_range(0, 1), $urandom_range(0, 7) == 0);
            s  = rand_addr();
            sz = 2'($urandom_range(0, 2));
            drive_req(s, ($urandom_range(0, 7) == 0) ? rand_addr() : s + (32'd1 << sz) - 1,
                      sz, $urandom_range(0, 7) == 0);
            bus.valid_dc1 = ($urandom_range(0, 3) != 0);
            tick();
            n_checks++;
            if (dc2_vec() !== m_res || bus.sideeffects_dc3 !== m_se3) begin
                n_errors++; $display("FAIL rnd_dc2 cyc %0d got %b/%b exp %b/%b", i, dc2_vec(), bus.sideeffects_dc3, m_res, m_se3);
            end
            n_checks++;
            if (cap_valid !== m_cap_valid || cap_addr !== m_cap_addr || cap_cause !== m_cap_cause ||
                fault_cnt !== CW'(m_cnt)) begin
                n_errors++; $display("FAIL rnd_cap cyc %0d got v%b a%h c%0d n%0d exp v%b a%h c%0d n%0d",
                    i, cap_valid, cap_addr, cap_cause, fault_cnt, m_cap_valid, m_cap_addr, m_cap_cause, m_cnt);
            end
        end
        rst = 0; freeze = 0; cap_clr = 0; set_cfg(0, 0, 0, 0, 0, 0); idle();
    endtask

    initial begin
        test_reset();
        test_external();
        test_window();
        test_lock_dma();
        test_dccm_pic();
        test_sideeffect_freeze();
        test_saturate_capture();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/lsu_addrcheck_win.md
# lsu_addrcheck_win

Parametrised, pipelined LSU address checker for the SweRV load/store path. Classifies each dc1 access as DCCM, PIC or external, checks it against `NUM_WIN` runtime-programmable, lockable data-access windows, and derives side-effect attributes from an MRAC-style CSR vector. Results are registered into dc2, with side-effect status also carried to dc3. A first-fault capture register and a saturating fault counter are provided for debug.

## Interface
- `NUM_WIN`, 8: number of access windows (1..16).
- `REGION_BITS`, 4: number of top address bits that select a region.
- `DCCM_SADR`, 32'hF004_0000: DCCM base address.
- `DCCM_SIZE`, 32'h1_0000: DCCM size in bytes (power of two).
- `PIC_SADR`, 32'hF00C_0000: PIC base address.
- `PIC_SIZE`, 32'h8000: PIC size in bytes (power of two).
- `CNT_W`, 16: fault counter width.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `freeze`  in  1  when 1, all pipeline, capture and counter state holds.
- `valid_dc1`, `dma_dc1`  in  1  request valid; request is a DMA access.
- `size_dc1`  in  2  0 = byte, 1 = half, 2 = word.
- `start_addr_dc1`, `end_addr_dc1`  in  32  first and last byte address of the access.
- `mrac`  in  2<<REGION_BITS  two bits per region: bit 2r+1 = side-effect, bit 2r = cacheable.
- `cfg_we`  in  1  window register write strobe.
- `cfg_idx`  in  $clog2(NUM_WIN)  window index to write.
- `cfg_base`, `cfg_mask`  in  32  window base address and don't-care mask.
- `cfg_en`, `cfg_lock`  in  1  window enable and lock.
- `valid_dc2`, `in_dccm_dc2`, `in_pic_dc2`, `external_dc2`  out  1  registered classification.
- `sideeffects_dc2`, `sideeffects_dc3`  out  1  side-effect attribute in dc2 and dc3.
- `access_fault_dc2`, `misaligned_fault_dc2`  out  1  fault flags.
- `fault_cause_dc2`  out  3  highest-priority fault cause.
- `cap_valid`, `cap_addr` [31:0], `cap_cause` [2:0]  out  first-fault capture register.
- `cap_clr`  in  1  clears the capture register.
- `fault_cnt`  out  CNT_W  saturating count of faults.

## Operation
**Window registers**
- Window i holds base, mask, en, lock.
- On `cfg_we`, window `cfg_idx` is written only if its lock bit is 0. A locked window can be cleared only by `rst`. An out-of-range `cfg_idx` is ignored.
- Window hit: `(addr | mask) == (base | mask)`, and en = 1.
- `win_ok`: 1 if no window is enabled. Otherwise, start_addr and end_addr must each hit some enabled window (they may hit different windows).

**Classification (combinational in dc1)**
- `dccm_rgn` / `pic_rgn`: the address's top `REGION_BITS` equal the top bits of the respective base.
- `in_dccm` / `in_pic`: start and end addresses both lie within [SADR, SADR + SIZE − 1].
- `external` = ~(in_dccm | in_pic).
- Side-effect = `mrac[2*start_region+1]` & ~(start in dccm_rgn | start in pic_rgn).
- Aligned: word accesses need addr[1:0] = 0; half accesses need addr[0] = 0; byte accesses are always aligned.

**Fault causes** (fault_cause reports the lowest-numbered active cause; 0 = none)
- 1: start or end address is in dccm_rgn but not in DCCM or PIC range.
- 2: start or end address is in pic_rgn but not in PIC/DCCM range, or the access crosses between DCCM and PIC.
- 3: PIC access that is not a word access or not word-aligned.
- 4: neither the dccm_rgn nor the pic_rgn contains the start address, and win_ok = 0.
- 5: external access whose start and end regions differ.
- 6: external side-effect access that is misaligned.

**Fault flags**
- `access_fault` = any of causes 1–4.
- `misaligned_fault` = cause 5 or 6.
- Both flags may assert together.
- All faults are forced to 0 when `valid_dc1` = 0 or `dma_dc1` = 1.

**Capture and counter**
- On a pipeline advance with a faulting request:
  - `fault_cnt` increments, saturating at all-ones.
  - If `cap_valid` = 0, the capture register loads start_addr and cause, and sets `cap_valid`.
- `cap_clr` clears `cap_valid`. If a new fault arrives in the same cycle as `cap_clr`, the new fault is captured and `cap_valid` stays 1.

## Timing
- On `rst`, every output and all state go to 0: all windows disabled and unlocked, `cap_*` = 0, `fault_cnt` = 0.
- When `freeze` = 0, all dc1 results register into dc2 at the next edge (latency 1), and `sideeffects_dc3` takes `sideeffects_dc2` one edge later.
- When `freeze` = 1, the dc2 and dc3 registers, the capture register and the counter all hold. `cfg_we` and `cap_clr` still take effect.
- A window write is visible to a dc1 check in the cycle after `cfg_we`. A check in the same cycle as the write uses the old window values.
- `valid_dc2` = 0 flushes nothing downstream. All dc2 outputs other than `sideeffects_dc2` are 0 when `valid_dc2` = 0.
- Asserting `rst` mid-stream discards in-flight dc2/dc3 state at that edge.

## Test plan
- Reset, then a word load at 0x2000_0000 → next cycle: `valid_dc2` = 1, `external_dc2` = 1, no faults, `fault_cnt` = 0.
- Program window 0 with base 0x2000_0000, mask 0x0FFF_FFFF, en = 1, then a word load at 0x3000_0000 → `access_fault_dc2` = 1, cause 4, `cap_addr` = 0x3000_0000, `fault_cnt` = 1. A load at 0x2000_0010 → no fault.
- Write window 0 with lock = 1, then rewrite it with en = 0 → the write is ignored and the load at 0x3000_0000 still faults with cause 4. A DMA access to the same address → no fault.
- Word load with start 0xF004_FFFE, end 0xF005_0001 → cause 1. Half access at 0xF00C_0000 → cause 3, `in_pic_dc2` = 1.
- `mrac[9]` = 1, half store at 0x4000_0001 → `misaligned_fault_dc2` = 1, cause 6, `sideeffects_dc2` = 1, with `sideeffects_dc3` = 1 one cycle later. Hold `freeze` = 1 for 3 cycles → all outputs stay unchanged.
- Preload `fault_cnt` to all-ones with repeated faults → the counter stays saturated. Assert `cap_clr` together with a new fault at 0x5000_0000 → `cap_valid` = 1 and `cap_addr` = 0x5000_0000.
